// File: rtl/alu_exec_pkg.sv
// Shared codes for the execute stage: ALU_OP classes, funct fields, 4-bit ctrl codes, FSM states.
package alu_exec_pkg;

  localparam logic [2:0] ALU_OP_SUB   = 3'b000;
  localparam logic [2:0] ALU_OP_ADD   = 3'b001;
  localparam logic [2:0] ALU_OP_SLT   = 3'b010;
  localparam logic [2:0] ALU_OP_AND   = 3'b011;
  localparam logic [2:0] ALU_OP_OR    = 3'b100;
  localparam logic [2:0] ALU_OP_ADDU  = 3'b101;
  localparam logic [2:0] ALU_OP_SUBU  = 3'b110;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b111;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    CTRL_AND     = 4'b0000,
    CTRL_OR      = 4'b0001,
    CTRL_ADD     = 4'b0010,
    CTRL_XOR     = 4'b0011,
    CTRL_MFHI    = 4'b0100,
    CTRL_MFLO    = 4'b0101,
    CTRL_SUB     = 4'b0110,
    CTRL_SLT     = 4'b0111,
    CTRL_MULTU   = 4'b1000,
    CTRL_DIVU    = 4'b1001,
    CTRL_ADDU    = 4'b1010,
    CTRL_SUBU    = 4'b1011,
    CTRL_NOR     = 4'b1100,
    CTRL_SLTU    = 4'b1101,
    CTRL_ILLEGAL = 4'b1111
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct -> ctrl decode, shared with the hazard unit.
// With ALU_EXEC_MDU_EN undefined, MFHI/MFLO/MULTU/DIVU decode as illegal.
module alu_ctrl_decode
  import alu_exec_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output ctrl_e      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_ILLEGAL;
    case (alu_op_i)
      ALU_OP_SUB:  ctrl_o = CTRL_SUB;
      ALU_OP_ADD:  ctrl_o = CTRL_ADD;
      ALU_OP_SLT:  ctrl_o = CTRL_SLT;
      ALU_OP_AND:  ctrl_o = CTRL_AND;
      ALU_OP_OR:   ctrl_o = CTRL_OR;
      ALU_OP_ADDU: ctrl_o = CTRL_ADDU;
      ALU_OP_SUBU: ctrl_o = CTRL_SUBU;
      default: begin
        case (funct_i)
          FUNCT_ADD:   ctrl_o = CTRL_ADD;
          FUNCT_ADDU:  ctrl_o = CTRL_ADDU;
          FUNCT_SUB:   ctrl_o = CTRL_SUB;
          FUNCT_SUBU:  ctrl_o = CTRL_SUBU;
          FUNCT_AND:   ctrl_o = CTRL_AND;
          FUNCT_OR:    ctrl_o = CTRL_OR;
          FUNCT_XOR:   ctrl_o = CTRL_XOR;
          FUNCT_NOR:   ctrl_o = CTRL_NOR;
          FUNCT_SLT:   ctrl_o = CTRL_SLT;
          FUNCT_SLTU:  ctrl_o = CTRL_SLTU;
`ifdef ALU_EXEC_MDU_EN
          FUNCT_MFHI:  ctrl_o = CTRL_MFHI;
          FUNCT_MFLO:  ctrl_o = CTRL_MFLO;
          FUNCT_MULTU: ctrl_o = CTRL_MULTU;
          FUNCT_DIVU:  ctrl_o = CTRL_DIVU;
`endif
          default:     ctrl_o = CTRL_ILLEGAL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: registered ALU plus optional iterative multu/divu unit with HI/LO.
// The multiply/divide unit is built only when ALU_EXEC_MDU_EN is defined.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  ctrl_e            ctrl;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill, alu_take;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  alu_ctrl_decode u_decode (
    .alu_op_i (alu_op),
    .funct_i  (funct),
    .ctrl_o   (ctrl)
  );

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

`ifdef ALU_EXEC_MDU_EN
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]     mul_sum, div_rem;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic               last_iter;

  // work_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_step  = {mul_sum, work_q[WIDTH-1:1]};
  assign div_rem   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_sub   = div_rem[WIDTH-1:0] - opnd_q;
  assign div_step  = (div_rem >= {1'b0, opnd_q}) ? {div_sub, work_q[WIDTH-2:0], 1'b1}
                                                 : {div_rem[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign in_ready = (state_q == ST_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;
`else
  assign in_ready = 1'b1;
  assign hi       = '0;
  assign lo       = '0;
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ctrl)
      CTRL_AND:  alu_res = src_a & src_b;
      CTRL_OR:   alu_res = src_a | src_b;
      CTRL_XOR:  alu_res = src_a ^ src_b;
      CTRL_NOR:  alu_res = ~(src_a | src_b);
      CTRL_ADDU: alu_res = sum;
      CTRL_SUBU: alu_res = diff;
      CTRL_ADD: begin
        alu_res = sum;
        alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      CTRL_SUB: begin
        alu_res = diff;
        alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      CTRL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
`ifdef ALU_EXEC_MDU_EN
      CTRL_MFHI: alu_res = hi_q;
      CTRL_MFLO: alu_res = lo_q;
`endif
      default:   alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = 1'b0;
    overflow_d  = 1'b0;
    illegal_d   = 1'b0;
    alu_take    = 1'b0;
`ifdef ALU_EXEC_MDU_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (ctrl == CTRL_MULTU) begin
            state_d = ST_MUL;
            cnt_d   = '0;
            work_d  = {{WIDTH{1'b0}}, src_b};
            opnd_d  = src_a;
          end else if (ctrl == CTRL_DIVU && src_b != '0) begin
            state_d = ST_DIV;
            cnt_d   = '0;
            work_d  = {{WIDTH{1'b0}}, src_a};
            opnd_d  = src_b;
          end else if (ctrl == CTRL_DIVU) begin
            // divide by zero retires immediately with a defined HI/LO
            hi_d        = src_a;
            lo_d        = '1;
            out_valid_d = 1'b1;
            result_d    = '1;
          end else begin
            alu_take = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        work_d = (state_q == ST_MUL) ? mul_step : div_step;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          hi_d        = work_d[2*WIDTH-1:WIDTH];
          lo_d        = work_d[WIDTH-1:0];
          out_valid_d = 1'b1;
          result_d    = work_d[WIDTH-1:0];
          zero_d      = (work_d[WIDTH-1:0] == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    alu_take = in_valid;
`endif
    if (alu_take) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      overflow_d  = alu_ovf;
      illegal_d   = alu_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_EXEC_MDU_EN
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
`ifdef ALU_EXEC_MDU_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit against an arithmetic reference model.
// Honours ALU_EXEC_MDU_EN the same way as the design.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   alu_op = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         in_ready, out_valid, zero, overflow, illegal;
  logic [W-1:0] result, hi, lo;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

`ifdef ALU_EXEC_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  typedef enum int {K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR,
                    K_SLT, K_SLTU, K_MFHI, K_MFLO, K_MULTU, K_DIVU, K_ILL} kind_t;

  int           n_checks = 0, n_pass = 0;
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         exp_valid = 1'b0, exp_zero = 1'b0, exp_ovf = 1'b0, exp_ill = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic [5:0]   legal [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h19, 6'h1B};

  task automatic chkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic kind_t kind_of(logic [2:0] op, logic [5:0] f);
    case (op)
      3'd0: return K_SUB;
      3'd1: return K_ADD;
      3'd2: return K_SLT;
      3'd3: return K_AND;
      3'd4: return K_OR;
      3'd5: return K_ADDU;
      3'd6: return K_SUBU;
      default: case (f)
        6'h20: return K_ADD;   6'h21: return K_ADDU;
        6'h22: return K_SUB;   6'h23: return K_SUBU;
        6'h24: return K_AND;   6'h25: return K_OR;
        6'h26: return K_XOR;   6'h27: return K_NOR;
        6'h2A: return K_SLT;   6'h2B: return K_SLTU;
        6'h10: return MDU ? K_MFHI : K_ILL;
        6'h12: return MDU ? K_MFLO : K_ILL;
        6'h19: return MDU ? K_MULTU : K_ILL;
        6'h1B: return MDU ? K_DIVU : K_ILL;
        default: return K_ILL;
      endcase
    endcase
  endfunction

  task automatic retire(logic [W-1:0] r, logic ovf, logic ill);
    exp_valid = 1'b1;
    exp_res   = r;
    exp_zero  = (r == '0);
    exp_ovf   = ovf;
    exp_ill   = ill;
    $display("txn done: result=%h ovf=%b ill=%b hi=%h lo=%h", r, ovf, ill, m_hi, m_lo);
  endtask

  task automatic model_reset();
    m_left = 0; m_hi = '0; m_lo = '0;
    exp_valid = 1'b0; exp_zero = 1'b0; exp_ovf = 1'b0; exp_ill = 1'b0; exp_res = '0;
  endtask

  // Reference behaviour at one rising edge, from the inputs presented at that edge.
  task automatic model_update();
    kind_t       k;
    longint      sa, sb, sr;
    logic [63:0] p;
    exp_valid = 1'b0; exp_zero = 1'b0; exp_ovf = 1'b0; exp_ill = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo;
        retire(p_lo, 1'b0, 1'b0);
      end
    end else if (in_valid) begin
      k  = kind_of(alu_op, funct);
      sa = longint'($signed(src_a));
      sb = longint'($signed(src_b));
      case (k)
        K_ADD: begin
          sr = sa + sb;
          retire(src_a + src_b, (sr > 64'sd2147483647) || (sr < -64'sd2147483648), 1'b0);
        end
        K_SUB: begin
          sr = sa - sb;
          retire(src_a - src_b, (sr > 64'sd2147483647) || (sr < -64'sd2147483648), 1'b0);
        end
        K_ADDU:  retire(src_a + src_b, 1'b0, 1'b0);
        K_SUBU:  retire(src_a - src_b, 1'b0, 1'b0);
        K_AND:   retire(src_a & src_b, 1'b0, 1'b0);
        K_OR:    retire(src_a | src_b, 1'b0, 1'b0);
        K_XOR:   retire(src_a ^ src_b, 1'b0, 1'b0);
        K_NOR:   retire(~(src_a | src_b), 1'b0, 1'b0);
        K_SLT:   retire({{(W-1){1'b0}}, sa < sb}, 1'b0, 1'b0);
        K_SLTU:  retire({{(W-1){1'b0}}, src_a < src_b}, 1'b0, 1'b0);
        K_MFHI:  retire(m_hi, 1'b0, 1'b0);
        K_MFLO:  retire(m_lo, 1'b0, 1'b0);
        K_MULTU: begin
          p = {32'b0, src_a} * {32'b0, src_b};
          p_hi = p[63:32]; p_lo = p[31:0];
          m_left = W;
        end
        K_DIVU: begin
          if (src_b == '0) begin
            m_hi = src_a; m_lo = '1;
            retire('1, 1'b0, 1'b0);
          end else begin
            p_lo = src_a / src_b; p_hi = src_a % src_b;
            m_left = W;
          end
        end
        default: retire('0, 1'b0, 1'b1);
      endcase
    end
  endtask

  task automatic compare();
    chk1("out_valid", out_valid, exp_valid);
    chk1("in_ready", in_ready, m_left == 0);
    chkw("hi", hi, m_hi);
    chkw("lo", lo, m_lo);
    if (exp_valid) begin
      chkw("result", result, exp_res);
      chk1("zero", zero, exp_zero);
      chk1("overflow", overflow, exp_ovf);
      chk1("illegal", illegal, exp_ill);
    end else begin
      chk1("zero_idle", zero, 1'b0);
      chk1("illegal_idle", illegal, 1'b0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    #1;
    compare();
  endtask

  task automatic issue(logic [2:0] op, logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
    in_valid = 1'b1; alu_op = op; funct = f; src_a = a; src_b = b;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!out_valid && n < 40);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  int n_cyc;

  initial begin
    model_reset();
    repeat (2) cycle();
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    chkw("reset_result", result, '0);
    chkw("reset_hi", hi, '0);
    rst_n = 1'b1;

    issue(3'b000, 6'h00, 32'd7, 32'd9);
    chkw("t1_result", result, 32'hFFFF_FFFE);
    chk1("t1_overflow", overflow, 1'b0);
    chk1("t1_zero", zero, 1'b0);

    issue(3'b111, 6'b100000, 32'h7FFF_FFFF, 32'd1);
    chkw("t2_add_result", result, 32'h8000_0000);
    chk1("t2_add_overflow", overflow, 1'b1);
    issue(3'b111, 6'b100001, 32'h7FFF_FFFF, 32'd1);
    chk1("t2_addu_overflow", overflow, 1'b0);

`ifdef ALU_EXEC_MDU_EN
    issue(3'b111, 6'b011001, 32'hFFFF_FFFF, 32'd2);
    chk1("t3_ready_low", in_ready, 1'b0);
    wait_done(n_cyc);
    chkw("t3_latency", 32'(n_cyc), 32'd32);
    chkw("t3_hi", hi, 32'd1);
    chkw("t3_lo", lo, 32'hFFFF_FFFE);
    chkw("t3_result", result, 32'hFFFF_FFFE);
    issue(3'b111, 6'b010000, 32'd0, 32'd0);
    chkw("t3_mfhi", result, 32'd1);

    issue(3'b111, 6'b011011, 32'd100, 32'd7);
    wait_done(n_cyc);
    chkw("t4_latency", 32'(n_cyc), 32'd32);
    chkw("t4_lo", lo, 32'd14);
    chkw("t4_hi", hi, 32'd2);
    issue(3'b111, 6'b011011, 32'd5, 32'd0);
    chk1("t4_div0_valid", out_valid, 1'b1);
    chkw("t4_div0_hi", hi, 32'd5);
    chkw("t4_div0_lo", lo, 32'hFFFF_FFFF);
`else
    issue(3'b111, 6'b011001, 32'hFFFF_FFFF, 32'd2);
    chk1("t3_multu_illegal", illegal, 1'b1);
    chkw("t3_multu_result", result, '0);
    chk1("t3_ready_high", in_ready, 1'b1);
    issue(3'b111, 6'b011011, 32'd5, 32'd0);
    chk1("t4_divu_illegal", illegal, 1'b1);
`endif

    issue(3'b111, 6'b111111, 32'd3, 32'd4);
    chk1("t5_valid", out_valid, 1'b1);
    chk1("t5_illegal", illegal, 1'b1);
    chkw("t5_result", result, '0);
`ifdef ALU_EXEC_MDU_EN
    chkw("t5_hi_kept", hi, 32'd5);
    chkw("t5_lo_kept", lo, 32'hFFFF_FFFF);
`else
    chkw("t5_hi_kept", hi, '0);
    chkw("t5_lo_kept", lo, '0);
`endif

    issue(3'b111, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    chkw("t5_rst_hi", hi, '0);
    chkw("t5_rst_lo", lo, '0);
    chk1("t5_rst_ready", in_ready, 1'b1);
    chk1("t5_rst_valid", out_valid, 1'b0);
    #2 rst_n = 1'b1;
    repeat (W + 4) cycle();

    issue(3'b100, 6'h00, 32'd5, 32'd10);
    chkw("t6_or", result, 32'd15);
    issue(3'b111, 6'b101011, 32'd1, 32'hFFFF_FFFF);
    chkw("t6_sltu", result, 32'd1);
    chk1("t6_sltu_valid", out_valid, 1'b1);
    issue(3'b010, 6'h00, 32'd1, 32'hFFFF_FFFF);
    chkw("t6_slt", result, 32'd0);
    chk1("t6_slt_valid", out_valid, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      alu_op   = 3'($urandom_range(0, 7));
      if (alu_op == 3'b111 && $urandom_range(0, 4) != 0) funct = legal[$urandom_range(0, 13)];
      else funct = 6'($urandom);
      src_a = pick();
      src_b = pick();
      cycle();
    end
    in_valid = 1'b0;
    repeat (W + 4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
